// File: rtl/tlul_resp_pkg.sv
// Shared types and helpers for the TileLink-UL D-channel responder.
package tlul_resp_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] D_ACK         = 3'd0;
  localparam logic [2:0] D_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic        source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } d_resp_t;

  // Byte lanes touched by an access of 2^size bytes starting at addr[1:0].
  function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      4'd0:    m = 4'b0001 << addr;
      4'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
      4'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlul_resp_fifo.sv
// Synchronous response FIFO; push is ignored when full, pop when empty.
module tlul_resp_fifo
  import tlul_resp_pkg::*;
#(
  parameter int RESP_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push_i,
  input  d_resp_t                     wdata_i,
  input  logic                        pop_i,
  output d_resp_t                     rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(RESP_DEPTH):0] count_o
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  d_resp_t         mem_q [RESP_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CW'(RESP_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tlul_d_responder.sv
// TileLink-UL slave backed by a word-addressed flop memory with queued D responses.
// Optional per-byte even parity when TLUL_RESP_PARITY_EN is defined.
module tlul_d_responder
  import tlul_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          MEM_WORDS  = 256,
  parameter int          RESP_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic        a_source,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        a_corrupt,
`ifdef TLUL_RESP_PARITY_EN
  input  logic        inj_parity_err,
`endif
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic        d_source,
  output logic        d_sink,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(RESP_DEPTH) + 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0]    mem_q [MEM_WORDS];
  logic [31:0]    offset, rd_word;
  logic [IDX_W-1:0] idx;
  logic [3:0]     lanes;
  logic           is_get, is_put, denied, a_fire, wr_en, par_err;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  d_resp_t        resp, head;
  logic           unused_bits;

  assign unused_bits = ^{a_param, offset[1:0]};

  assign offset = a_address - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  assign lanes  = lane_mask(a_size, a_address[1:0]);
  assign is_get = (a_opcode == A_GET);
  assign is_put = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);

  always_comb begin
    denied = 1'b0;
    if (!is_get && !is_put)                              denied = 1'b1;
    if (a_size > 4'd2)                                   denied = 1'b1;
    if (a_size == 4'd1 && a_address[0])                  denied = 1'b1;
    if (a_size == 4'd2 && a_address[1:0] != 2'b00)       denied = 1'b1;
    if (a_address < BASE_ADDR || offset >= MEM_BYTES)    denied = 1'b1;
    if ((a_mask & ~lanes) != 4'b0 || a_mask == 4'b0)     denied = 1'b1;
    if (a_opcode == A_PUT_FULL && a_mask != lanes)       denied = 1'b1;
    if (is_put && a_corrupt)                             denied = 1'b1;
  end

  // Writes are gated by reset so a request presented during reset has no effect.
  assign a_ready = ~fifo_full;
  assign a_fire  = a_valid & a_ready & ~reset;
  assign wr_en   = a_fire & is_put & ~denied;
  assign rd_word = mem_q[idx];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

`ifdef TLUL_RESP_PARITY_EN
  logic [3:0] par_q [MEM_WORDS];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) par_q[idx][b] <= ^a_data[8*b +: 8] ^ inj_parity_err;
      end
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if ((^rd_word[8*b +: 8]) != par_q[idx][b]) par_err = 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    resp         = '0;
    resp.opcode  = is_get ? D_ACK_DATA : D_ACK;
    resp.size    = a_size;
    resp.source  = a_source;
    resp.denied  = denied;
    resp.data    = (is_get && !denied) ? rd_word : 32'h0;
    resp.corrupt = denied | (is_get & par_err);
  end

  tlul_resp_fifo #(.RESP_DEPTH(RESP_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (a_fire),
    .wdata_i (resp),
    .pop_i   (d_valid & d_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clock) disable iff (reset)
                   fifo_full == (fifo_count == CW'(RESP_DEPTH)));

  // Idle D fields read as zero rather than exposing stale FIFO contents.
  assign d_valid   = ~fifo_empty;
  assign d_opcode  = d_valid ? head.opcode  : 3'd0;
  assign d_size    = d_valid ? head.size    : 4'd0;
  assign d_source  = d_valid ? head.source  : 1'b0;
  assign d_denied  = d_valid ? head.denied  : 1'b0;
  assign d_data    = d_valid ? head.data    : 32'h0;
  assign d_corrupt = d_valid ? head.corrupt : 1'b0;
  assign d_param   = 2'd0;
  assign d_sink    = 1'b0;

endmodule

// File: tb/tb_tlul_d_responder.sv
// Self-checking bench for tlul_d_responder: directed scenarios plus random traffic against a byte-level model.
module tb_tlul_d_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NBYTES = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [3:0]  a_size = '0;
  logic        a_source = 1'b0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_corrupt = 1'b0;
`ifdef TLUL_RESP_PARITY_EN
  logic        inj_parity_err = 1'b0;
`endif
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;

  tlul_d_responder dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_corrupt (a_corrupt),
`ifdef TLUL_RESP_PARITY_EN
    .inj_parity_err (inj_parity_err),
`endif
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_denied  (d_denied),
    .d_data    (d_data),
    .d_corrupt (d_corrupt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic        source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } exp_t;

  logic [7:0] mem_m   [NBYTES];
  bit         par_bad [NBYTES];
  exp_t       exp_q[$];
  logic       src_log[$];
  bit         cur_inj = 0;

  // Behavioural model: decode straight from the access rules, then update byte memory.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] sz, input logic src,
                                 input logic [31:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data, input logic cor, input bit inj);
    exp_t e;
    longint off = longint'(addr) - longint'(BASE);
    int     a4  = int'(addr % 4);
    logic [3:0] cov = '0;
    bit     den = 0;
    bit     pbad = 0;
    int     wbase;
    if (op != 0 && op != 1 && op != 4) den = 1;
    if (sz > 2) den = 1;
    else begin
      if (addr % (32'd1 << sz) != 0) den = 1;
      for (int b = 0; b < 4; b++)
        if (b >= a4 && b < a4 + (1 << sz)) cov[b] = 1'b1;
    end
    if (off < 0 || off >= NBYTES) den = 1;
    if ((mask & ~cov) != 0 || mask == 0) den = 1;
    if (op == 0 && mask != cov) den = 1;
    if ((op == 0 || op == 1) && cor) den = 1;
    e.opcode = (op == 4) ? 3'd1 : 3'd0;
    e.size = sz;
    e.source = src;
    e.denied = den;
    e.data = 0;
    e.corrupt = den;
    if (!den) begin
      wbase = int'(off) & ~3;
      if (op == 4) begin
        for (int b = 0; b < 4; b++) begin
          e.data[8*b +: 8] = mem_m[wbase + b];
          if (par_bad[wbase + b]) pbad = 1;
        end
`ifdef TLUL_RESP_PARITY_EN
        e.corrupt = pbad;
`endif
      end else begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) begin
            mem_m[wbase + b] = data[8*b +: 8];
            par_bad[wbase + b] = inj;
          end
      end
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (d_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_d_valid", 32'(d_valid), 32'd0);
        end else begin
          check("d_opcode",  32'(d_opcode),  32'(exp_q[0].opcode));
          check("d_size",    32'(d_size),    32'(exp_q[0].size));
          check("d_source",  32'(d_source),  32'(exp_q[0].source));
          check("d_denied",  32'(d_denied),  32'(exp_q[0].denied));
          check("d_data",    d_data,         exp_q[0].data);
          check("d_corrupt", 32'(d_corrupt), 32'(exp_q[0].corrupt));
          check("d_param",   32'(d_param),   32'd0);
          check("d_sink",    32'(d_sink),    32'd0);
          if (d_ready) begin
            src_log.push_back(d_source);
            void'(exp_q.pop_front());
          end
        end
      end
      if (a_valid && a_ready)
        exp_q.push_back(model(a_opcode, a_size, a_source, a_address, a_mask, a_data, a_corrupt, cur_inj));
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the request has fired.
  task automatic send(input logic [2:0] op, input logic [3:0] sz, input logic src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic cor, input bit inj);
    bit ok = 0;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
    cur_inj = inj;
`ifdef TLUL_RESP_PARITY_EN
    inj_parity_err = inj;
`endif
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (a_ready) ok = 1;
    end
    if (!ok) check("a_ready_timeout", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    a_valid = 1'b0;
    cur_inj = 0;
`ifdef TLUL_RESP_PARITY_EN
    inj_parity_err = 1'b0;
`endif
  endtask

  bit rnd_ready = 0;
  initial forever begin
    @(posedge clock); #1;
    if (rnd_ready) d_ready = ($urandom_range(0, 2) != 0);
  end

  bit bp_done = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sz, msk;
    logic [2:0]  op;
    logic [31:0] addr;
    int          r;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_opcode", 32'(d_opcode), 32'd0);
    check("rst_d_data", d_data, 32'd0);
    @(posedge clock); #1;

    for (int w = 0; w < 256; w++)
      send(3'd0, 4'd2, 1'b0, BASE + 32'(w * 4), 4'hF, $urandom, 1'b0, 0);
    repeat (2) @(posedge clock); #1;

    send(3'd0, 4'd2, 1'b0, 32'h8000_0004, 4'hF, 32'hDEADBEEF, 1'b0, 0);
    @(negedge clock);
    check("put_latency_d_valid", 32'(d_valid), 32'd1);
    check("put_d_opcode", 32'(d_opcode), 32'd0);
    check("put_d_denied", 32'(d_denied), 32'd0);
    @(posedge clock); #1;
    send(3'd4, 4'd2, 1'b1, 32'h8000_0004, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clock);
    check("get_latency_d_valid", 32'(d_valid), 32'd1);
    check("get_d_opcode", 32'(d_opcode), 32'd1);
    check("get_d_data", d_data, 32'hDEADBEEF);
    @(posedge clock); #1;

    send(3'd1, 4'd0, 1'b0, 32'h8000_0005, 4'h2, 32'h0000_5500, 1'b0, 0);
    send(3'd4, 4'd2, 1'b0, 32'h8000_0004, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clock);
    check("partial_d_data", d_data, 32'hDEAD55EF);
    @(posedge clock); #1;

    send(3'd4, 4'd2, 1'b0, 32'h8000_0400, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clock);
    check("oor_d_opcode", 32'(d_opcode), 32'd1);
    check("oor_d_denied", 32'(d_denied), 32'd1);
    check("oor_d_corrupt", 32'(d_corrupt), 32'd1);
    check("oor_d_data", d_data, 32'd0);
    @(posedge clock); #1;
    send(3'd4, 4'd2, 1'b0, 32'h8000_0002, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clock);
    check("misalign_d_denied", 32'(d_denied), 32'd1);
    @(posedge clock); #1;

    // Backpressure: two entries fill the queue, the third waits.
    src_log.delete();
    d_ready = 1'b0;
    fork
      begin
        send(3'd4, 4'd2, 1'b0, BASE + 32'h8,  4'hF, 32'h0, 1'b0, 0);
        send(3'd4, 4'd2, 1'b1, BASE + 32'hC,  4'hF, 32'h0, 1'b0, 0);
        send(3'd4, 4'd2, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 0);
        bp_done = 1;
      end
    join_none
    repeat (5) @(negedge clock);
    check("bp_a_ready", 32'(a_ready), 32'd0);
    check("bp_d_valid", 32'(d_valid), 32'd1);
    check("bp_queued", 32'(exp_q.size()), 32'd2);
    @(posedge clock); #1;
    d_ready = 1'b1;
    for (int i = 0; i < 50 && !bp_done; i++) @(negedge clock);
    check("bp_third_accepted", 32'(bp_done), 32'd1);
    repeat (4) @(negedge clock);
    check("bp_drain_count", 32'(src_log.size()), 32'd3);
    if (src_log.size() == 3) begin
      check("bp_src0", 32'(src_log[0]), 32'd0);
      check("bp_src1", 32'(src_log[1]), 32'd1);
      check("bp_src2", 32'(src_log[2]), 32'd0);
    end
    @(posedge clock); #1;

    // Reset with two responses queued.
    d_ready = 1'b0;
    send(3'd4, 4'd2, 1'b0, BASE, 4'hF, 32'h0, 1'b0, 0);
    send(3'd4, 4'd2, 1'b1, BASE + 32'h4, 4'hF, 32'h0, 1'b0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("flush_d_valid", 32'(d_valid), 32'd0);
    check("flush_a_ready", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    d_ready = 1'b1;
    repeat (5) @(posedge clock); #1;
    send(3'd4, 4'd2, 1'b1, 32'h8000_0004, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clock);
    check("post_flush_d_data", d_data, 32'hDEAD55EF);
    @(posedge clock); #1;

`ifdef TLUL_RESP_PARITY_EN
    send(3'd0, 4'd2, 1'b0, BASE + 32'h20, 4'hF, 32'h1234_5678, 1'b0, 1);
    send(3'd4, 4'd2, 1'b0, BASE + 32'h20, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clock);
    check("par_d_corrupt", 32'(d_corrupt), 32'd1);
    check("par_d_denied", 32'(d_denied), 32'd0);
    check("par_d_data", d_data, 32'h1234_5678);
    @(posedge clock); #1;
`endif

    rnd_ready = 1;
    for (int t = 0; t < 400; t++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 3'd4 : (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      if (r < 8)       addr = BASE + 32'($urandom_range(0, 1023));
      else if (r == 8) addr = BASE + 32'd1024 + 32'($urandom_range(0, 255));
      else             addr = BASE - 32'd1 - 32'($urandom_range(0, 255));
      if (sz <= 2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      msk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 7 && sz <= 2) begin
        msk = 4'h0;
        for (int b = 0; b < 4; b++)
          if (b >= int'(addr % 4) && b < int'(addr % 4) + (1 << sz)) msk[b] = 1'b1;
        if (op == 3'd1 && msk != 4'h0) msk = msk & 4'($urandom_range(1, 15));
      end
      send(op, sz, 1'($urandom_range(0, 1)), addr, msk, $urandom,
           1'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 7) == 0));
    end
    rnd_ready = 0;
    @(posedge clock); #2;
    d_ready = 1'b1;
    repeat (6) @(negedge clock);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check("final_d_valid", 32'(d_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlul_d_responder.md
Name: tlul_d_responder

Overview:
- TileLink-UL slave endpoint for the hart data port: accepts A-channel requests and drives the D-channel response bundle (ready/valid, opcode, param, size, source, sink, denied, data, corrupt) back to the hart.
- Backs requests with a small local word-addressed flop memory.
- Queues responses in a small FIFO so D-side backpressure never loses data.
- Used as a bring-up and verification target for hart data traffic.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of memory word 0.
- MEM_WORDS, 256, number of 32-bit words; power of 2, minimum 4.
- RESP_DEPTH, 2, response FIFO entries; power of 2, minimum 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted when high with a_valid.
- a_opcode  in  3  0 = PutFullData, 1 = PutPartialData, 4 = Get.
- a_param  in  3  ignored; must be 0.
- a_size  in  4  log2 of the byte count.
- a_source  in  1  echoed on d_source.
- a_address  in  32  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data poisoned.
- d_valid  out  1  response valid.
- d_ready  in  1  response accepted.
- d_opcode  out  3  0 = AccessAck, 1 = AccessAckData.
- d_param  out  2  always 0.
- d_size  out  4  echo of a_size.
- d_source  out  1  echo of a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  request rejected.
- d_data  out  32  read data; 0 for AccessAck.
- d_corrupt  out  1  data invalid.

Behaviour:
- Reset state: d_valid = 0, FIFO empty, all other D fields 0, a_ready = 1 on the first cycle after reset deasserts. Memory is not reset.
- Reset mid-operation flushes queued responses. No D beat is emitted for a flushed entry.
- A fire = a_valid & a_ready. a_ready = !full, where full is registered FIFO count == RESP_DEPTH. A simultaneous D dequeue does not raise a_ready in the same cycle.
- On A fire, the request is decoded and executed against memory in the same cycle, and the response is enqueued. Earliest d_valid is the next cycle (latency 1).
- Responses are issued strictly in A order.
- D fields are held stable while d_valid & !d_ready. Dequeue on d_valid & d_ready.
- Enqueue and dequeue may occur in the same cycle while not full; the count is unchanged.
- Denied, with no memory write, if any of the following hold:
  - opcode not in {0, 1, 4};
  - a_size > 2;
  - address not aligned to 2^a_size;
  - address outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS);
  - a_mask has bits outside the lanes covered by size and address, or a_mask == 0;
  - PutFullData whose mask is not exactly the covered lanes;
  - a_corrupt = 1 on a Put.
- Get response: d_opcode = 1, d_data = full word at address[…:2] (all lanes returned), d_denied = 0, d_corrupt = 0.
- Denied Get: d_opcode = 1, d_denied = 1, d_corrupt = 1, d_data = 0.
- Put response: d_opcode = 0, d_data = 0, d_corrupt = 0. Only masked bytes are written.
- Denied Put: d_opcode = 0, d_denied = 1.
- A Get following a Put to the same word observes the new data, because memory is updated at A fire.
- Word index = (a_address - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits after the range check.

Optional Feature:
- TLUL_RESP_PARITY_EN defined: one even-parity bit per memory byte, written with each byte.
  - A Get whose returned word has any parity mismatch responds with d_corrupt = 1, d_denied = 0, and the data as read.
  - Adds input port inj_parity_err (1 bit). When it is high on a Put fire, the stored parity bits of the written bytes are inverted.
- Not defined: no parity storage, no inj_parity_err port, d_corrupt = d_denied.

Decomposition:
- Package tlul_resp_pkg holds:
  - opcode localparams (A_PUT_FULL = 0, A_PUT_PARTIAL = 1, A_GET = 4, D_ACK = 0, D_ACK_DATA = 1);
  - typedef d_resp_t {opcode, size, source, denied, data, corrupt};
  - the lane-mask function (size, addr[1:0]) -> 4-bit mask.
- One sub-module, tlul_resp_fifo: synchronous FIFO of d_resp_t, parameter RESP_DEPTH, outputs full/empty/count.

Test Plan:
- Reset, then PutFull addr 0x8000_0004, data 0xDEADBEEF, mask 0xF, then Get same address, size 2 -> AccessAck denied = 0, then AccessAckData data 0xDEADBEEF; each d_valid exactly 1 cycle after its A fire.
- PutPartial addr 0x8000_0004, mask 0x2, data 0x0000_5500, then Get -> d_data 0xDEAD55EF.
- Get addr 0x8000_0400 (out of range, MEM_WORDS = 256) -> d_opcode 1, d_denied 1, d_corrupt 1, d_data 0. Get addr 0x8000_0002 size 2 (misaligned) -> denied.
- Hold d_ready = 0 and issue 3 Gets -> a_ready drops after 2 accepts; the D bundle stays stable. Release d_ready -> responses drain in order with sources 0, 1, 0; the third request is then accepted.
- Assert reset while the FIFO holds 2 entries -> next cycle d_valid = 0; no stale response appears afterwards.
- (TLUL_RESP_PARITY_EN) Put with inj_parity_err = 1, then Get -> d_corrupt 1, d_denied 0.
